// File: rtl/l2_bank_router_pkg.sv
// Shared field widths, bank count and payload types for the L2 bank router slice.
package l2_bank_router_pkg;

    localparam int unsigned OP_BITS      = 3;
    localparam int unsigned SIZE_BITS    = 3;
    localparam int unsigned SOURCE_BITS  = 8;
    localparam int unsigned ADDRESS_BITS = 32;
    localparam int unsigned MASK_BITS    = 4;
    localparam int unsigned DATA_BITS    = 32;
    localparam int unsigned PARAM_BITS   = 3;
    localparam int unsigned NUM_L2CACHE  = 2;

    typedef struct packed {
        logic [OP_BITS-1:0]      opcode;
        logic [SIZE_BITS-1:0]    size;
        logic [SOURCE_BITS-1:0]  source;
        logic [ADDRESS_BITS-1:0] address;
        logic [MASK_BITS-1:0]    mask;
        logic [DATA_BITS-1:0]    data;
        logic [PARAM_BITS-1:0]   param;
    } l2_req_t;

    typedef struct packed {
        logic [OP_BITS-1:0]      opcode;
        logic [SIZE_BITS-1:0]    size;
        logic [SOURCE_BITS-1:0]  source;
        logic [ADDRESS_BITS-1:0] address;
        logic [DATA_BITS-1:0]    data;
        logic [PARAM_BITS-1:0]   param;
    } l2_rsp_t;

    // Index width that stays legal (>=1 bit) for a single-entry selection.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2_bank_router_rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, wraps, and moves the
// pointer past the winner only when a grant is actually issued.
module rr_arbiter
    import l2_bank_router_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    localparam int unsigned PTR_W = sel_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_i,
    input  logic             advance_i,
    output logic [WIDTH-1:0] grant_o,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        idx     = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            idx = PTR_W'((32'(ptr_q) + i) % WIDTH);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                if (advance_i) begin
                    grant_o[idx] = 1'b1;
                    ptr_d        = (32'(idx) + 1 == WIDTH) ? '0 : idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/l2_bank_router.sv
// Steers the merged request stream to an address-selected L2 bank and merges
// bank responses round-robin; one register stage per direction.
module l2_bank_router
    import l2_bank_router_pkg::*;
#(
    parameter int unsigned NUM_BANK        = NUM_L2CACHE,
    parameter int unsigned BANK_SEL_LSB    = 6,
    parameter int unsigned MAX_OUTSTANDING = 64,
    parameter int unsigned CNT_BITS        = 7
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic                             req_in_valid_i,
    output logic                             req_in_ready_o,
    input  logic [OP_BITS-1:0]               req_in_opcode_i,
    input  logic [SIZE_BITS-1:0]             req_in_size_i,
    input  logic [SOURCE_BITS-1:0]           req_in_source_i,
    input  logic [ADDRESS_BITS-1:0]          req_in_address_i,
    input  logic [MASK_BITS-1:0]             req_in_mask_i,
    input  logic [DATA_BITS-1:0]             req_in_data_i,
    input  logic [PARAM_BITS-1:0]            req_in_param_i,

    output logic [NUM_BANK-1:0]              req_bank_valid_o,
    input  logic [NUM_BANK-1:0]              req_bank_ready_i,
    output logic [NUM_BANK*OP_BITS-1:0]      req_bank_opcode_o,
    output logic [NUM_BANK*SIZE_BITS-1:0]    req_bank_size_o,
    output logic [NUM_BANK*SOURCE_BITS-1:0]  req_bank_source_o,
    output logic [NUM_BANK*ADDRESS_BITS-1:0] req_bank_address_o,
    output logic [NUM_BANK*MASK_BITS-1:0]    req_bank_mask_o,
    output logic [NUM_BANK*DATA_BITS-1:0]    req_bank_data_o,
    output logic [NUM_BANK*PARAM_BITS-1:0]   req_bank_param_o,

    input  logic [NUM_BANK-1:0]              rsp_bank_valid_i,
    output logic [NUM_BANK-1:0]              rsp_bank_ready_o,
    input  logic [NUM_BANK*OP_BITS-1:0]      rsp_bank_opcode_i,
    input  logic [NUM_BANK*SIZE_BITS-1:0]    rsp_bank_size_i,
    input  logic [NUM_BANK*SOURCE_BITS-1:0]  rsp_bank_source_i,
    input  logic [NUM_BANK*ADDRESS_BITS-1:0] rsp_bank_address_i,
    input  logic [NUM_BANK*DATA_BITS-1:0]    rsp_bank_data_i,
    input  logic [NUM_BANK*PARAM_BITS-1:0]   rsp_bank_param_i,

    output logic                             rsp_out_valid_o,
    input  logic                             rsp_out_ready_i,
    output logic [OP_BITS-1:0]               rsp_out_opcode_o,
    output logic [SIZE_BITS-1:0]             rsp_out_size_o,
    output logic [SOURCE_BITS-1:0]           rsp_out_source_o,
    output logic [ADDRESS_BITS-1:0]          rsp_out_address_o,
    output logic [DATA_BITS-1:0]             rsp_out_data_o,
    output logic [PARAM_BITS-1:0]            rsp_out_param_o,

    output logic [CNT_BITS-1:0]              outstanding_o,
    output logic                             idle_o
);

    localparam int unsigned BSEL_W = sel_width(NUM_BANK);
    localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_OUTSTANDING);

    // ---------------------------------------------------------------- request
    l2_req_t           req_in;
    l2_req_t           req_q, req_d;
    logic              rv_q, rv_d;
    logic [BSEL_W-1:0] bank_in;
    logic [BSEL_W-1:0] bank_q, bank_d;
    logic              req_fire;
    logic              req_load;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    assign req_in = '{
        opcode:  req_in_opcode_i,
        size:    req_in_size_i,
        source:  req_in_source_i,
        address: req_in_address_i,
        mask:    req_in_mask_i,
        data:    req_in_data_i,
        param:   req_in_param_i
    };

    if (NUM_BANK > 1) begin : g_bank_sel
        assign bank_in = req_in_address_i[BANK_SEL_LSB +: BSEL_W];
    end else begin : g_bank_single
        assign bank_in = '0;
    end

    assign req_fire       = rv_q && req_bank_ready_i[bank_q];
    assign req_in_ready_o = (!rv_q || req_fire) && (cnt_q < MAX_CNT);
    assign req_load       = req_in_valid_i && req_in_ready_o;

    always_comb begin
        rv_d   = rv_q;
        req_d  = req_q;
        bank_d = bank_q;
        if (req_load) begin
            rv_d   = 1'b1;
            req_d  = req_in;
            bank_d = bank_in;
        end else if (req_fire) begin
            rv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_q   <= 1'b0;
            req_q  <= '0;
            bank_q <= '0;
        end else begin
            rv_q   <= rv_d;
            req_q  <= req_d;
            bank_q <= bank_d;
        end
    end

    assign req_bank_valid_o   = rv_q ? (NUM_BANK'(1) << bank_q) : '0;
    assign req_bank_opcode_o  = {NUM_BANK{req_q.opcode}};
    assign req_bank_size_o    = {NUM_BANK{req_q.size}};
    assign req_bank_source_o  = {NUM_BANK{req_q.source}};
    assign req_bank_address_o = {NUM_BANK{req_q.address}};
    assign req_bank_mask_o    = {NUM_BANK{req_q.mask}};
    assign req_bank_data_o    = {NUM_BANK{req_q.data}};
    assign req_bank_param_o   = {NUM_BANK{req_q.param}};

    // --------------------------------------------------------------- response
    l2_rsp_t              rsp_bank [NUM_BANK];
    l2_rsp_t              rsp_sel;
    l2_rsp_t              rsp_q, rsp_d;
    logic                 ov_q, ov_d;
    logic                 rsp_load_ok;
    logic                 rsp_out_fire;
    logic [NUM_BANK-1:0]  rsp_grant;
    logic [BSEL_W-1:0]    rr_ptr;

    for (genvar k = 0; k < NUM_BANK; k++) begin : g_rsp_unpack
        assign rsp_bank[k] = '{
            opcode:  rsp_bank_opcode_i[k*OP_BITS +: OP_BITS],
            size:    rsp_bank_size_i[k*SIZE_BITS +: SIZE_BITS],
            source:  rsp_bank_source_i[k*SOURCE_BITS +: SOURCE_BITS],
            address: rsp_bank_address_i[k*ADDRESS_BITS +: ADDRESS_BITS],
            data:    rsp_bank_data_i[k*DATA_BITS +: DATA_BITS],
            param:   rsp_bank_param_i[k*PARAM_BITS +: PARAM_BITS]
        };
    end

    assign rsp_load_ok  = !ov_q || rsp_out_ready_i;
    assign rsp_out_fire = ov_q && rsp_out_ready_i;

    rr_arbiter #(
        .WIDTH (NUM_BANK)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req_i     (rsp_bank_valid_i),
        .advance_i (rsp_load_ok),
        .grant_o   (rsp_grant),
        .ptr_o     (rr_ptr)
    );

    assign rsp_bank_ready_o = rsp_grant;

    // Grant is one-hot, so an AND-OR mux picks the winning payload.
    always_comb begin
        rsp_sel = '0;
        for (int unsigned k = 0; k < NUM_BANK; k++) begin
            if (rsp_grant[k]) begin
                rsp_sel = rsp_sel | rsp_bank[k];
            end
        end
    end

    always_comb begin
        ov_d  = ov_q;
        rsp_d = rsp_q;
        if (|rsp_grant) begin
            ov_d  = 1'b1;
            rsp_d = rsp_sel;
        end else if (rsp_out_ready_i) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_q  <= 1'b0;
            rsp_q <= '0;
        end else begin
            ov_q  <= ov_d;
            rsp_q <= rsp_d;
        end
    end

    assign rsp_out_valid_o   = ov_q;
    assign rsp_out_opcode_o  = rsp_q.opcode;
    assign rsp_out_size_o    = rsp_q.size;
    assign rsp_out_source_o  = rsp_q.source;
    assign rsp_out_address_o = rsp_q.address;
    assign rsp_out_data_o    = rsp_q.data;
    assign rsp_out_param_o   = rsp_q.param;

    // ------------------------------------------------------ outstanding count
    always_comb begin
        cnt_d = cnt_q;
        unique case ({req_load, rsp_out_fire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign idle_o        = (cnt_q == '0) && !rv_q && !ov_q;

    // A response with nothing outstanding means the bank protocol was broken.
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(rsp_out_fire && !req_load && cnt_q == '0));

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        cnt_q <= MAX_CNT);

    a_ptr_range: assert property (@(posedge clk) disable iff (rst)
        32'(rr_ptr) < NUM_BANK);

endmodule

// File: doc/l2_bank_router.md
Name: l2_bank_router

Overview:
- Sits on the L2 side of the cluster-to-L2 interface, after the cluster arbiter.
- Takes the single merged TileLink-style request stream and steers each request to one of NUM_BANK L2 cache banks, selected by address bits.
- Collects the banks' responses with a round-robin arbiter into the single response stream that returns to the cluster arbiter.
- Both directions are registered, one stage each, and the block keeps an outstanding-transaction count for idle detection.

Parameters:
- NUM_BANK, 2, number of L2 banks; power of two, at least 1.
- BANK_SEL_LSB, 6, lowest address bit of the bank-select field (above the cache-line offset).
- MAX_OUTSTANDING, 64, request acceptance stalls once this many requests are in flight.
- CNT_BITS, 7, width of the outstanding counter; must satisfy 2^CNT_BITS > MAX_OUTSTANDING.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_in_valid_i / req_in_ready_o  in/out  1/1  merged request handshake
- req_in_{opcode,size,source,address,mask,data,param}_i  in  `OP_BITS/`SIZE_BITS/`SOURCE_BITS/`ADDRESS_BITS/`MASK_BITS/`DATA_BITS/`PARAM_BITS  request fields
- req_bank_valid_o / req_bank_ready_i  out/in  NUM_BANK/NUM_BANK  per-bank request handshake
- req_bank_{opcode,...,param}_o  out  NUM_BANK*field width  per-bank request fields; all banks carry the same registered payload
- rsp_bank_valid_i / rsp_bank_ready_o  in/out  NUM_BANK/NUM_BANK  per-bank response handshake
- rsp_bank_{opcode,size,source,address,data,param}_i  in  NUM_BANK*field width  per-bank response fields
- rsp_out_valid_o / rsp_out_ready_i  out/in  1/1  merged response handshake
- rsp_out_{opcode,size,source,address,data,param}_o  out  field widths  merged response fields
- outstanding_o  out  CNT_BITS  requests accepted but not yet answered
- idle_o  out  1  high when outstanding_o==0, no request is held, and no response is held

Behaviour:
- Reset (asynchronous): all pipeline valids are 0; outstanding_o=0; round-robin pointer=0; idle_o=1; payload registers are 0.
- Bank select: bank = address[BANK_SEL_LSB +: log2(NUM_BANK)]; when NUM_BANK==1, bank=0.
- Request stage: a single register holding the payload, the bank index, and a valid bit (rv).
  - req_in_ready_o = (!rv || fire_out) && (outstanding_o < MAX_OUTSTANDING).
  - fire_out = rv && req_bank_ready_i[bank_q].
  - req_bank_valid_o[k] = rv && (k==bank_q); no other bank sees valid.
  - A new request may load in the same cycle that the held one fires, giving full throughput and one cycle of latency.
  - A held request never changes while rv=1 and it is not accepted.
- Response arbiter: round-robin over rsp_bank_valid_i, searching from pointer ptr upward and wrapping.
  - A bank is granted only when the output register can load: !ov || rsp_out_ready_i.
  - rsp_bank_ready_o is one-hot at the granted bank and all-zero otherwise.
  - On a grant, the winning payload loads the output register and ptr becomes (winner+1) mod NUM_BANK.
  - ptr is unchanged when nothing is granted.
- Response output: rsp_out_valid_o=ov; fields come from the register. Payload is stable while ov=1 && !rsp_out_ready_i. Latency is one cycle from bank handshake to output.
- Outstanding counter:
  - +1 on an accepted req_in handshake; -1 on an rsp_out handshake; unchanged if both or neither happen in the same cycle.
  - A response with the counter at 0 is a protocol error: the counter saturates at 0 and a simulation assertion fires.
  - The counter never exceeds MAX_OUTSTANDING.
- The source field passes through unmodified in both directions; the cluster bits in the source are not interpreted here.
- Reset mid-transfer drops the held request and the held response; upstream blocks are reset together with this block.

Decomposition:
- Field widths (`OP_BITS etc.) come from the existing define.v.
- Add `NUM_L2CACHE to the shared defines for NUM_BANK.
- One sub-module: rr_arbiter (parameter WIDTH; inputs req, advance; outputs one-hot grant and the registered pointer). It is reusable elsewhere in the codebase.

Test Plan:
- NUM_BANK=2, BANK_SEL_LSB=6: request addr 0x40 -> req_bank_valid_o=2'b10 one cycle later; addr 0x80 -> 2'b01; fields identical to the input.
- Back-to-back requests to bank0 with req_bank_ready_i=1 -> one per cycle and req_in_ready_o held at 1; drop bank0 ready for 3 cycles -> payload stable, req_in_ready_o=0, then resumes with no loss or duplication.
- Both banks hold valid responses continuously -> grants alternate 0,1,0,1 starting at bank0 after reset; with rsp_out_ready_i=0 -> rsp_bank_ready_o=0 and the output is stable.
- MAX_OUTSTANDING=4: 4 requests accepted with no responses -> outstanding_o=4 and req_in_ready_o=0; one response handshake -> 3, and ready returns.
- Simultaneous request accept and response handshake -> outstanding_o unchanged; idle_o=1 only after the final response drains.
- Assert rst while both rv=1 and ov=1 -> all valids are 0 immediately (asynchronously), outstanding_o=0, and arbitration restarts at bank0.
